// File: rtl/sa_host_seq.sv
// Host-port sequencer for the systolic array top: loads weights and activations,
// optionally presets the output buffer, starts the array, polls done, streams results.
module sa_host_seq #(
    parameter int MAC_W   = 19,
    parameter int X_W     = 8,
    parameter int TIMEOUT = 255,
    parameter int GUARD   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_start_i,
    input  logic             cmd_clr_i,
    input  logic [MAC_W-1:0] cmd_cdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic [X_W-1:0]   in_data_i,
    input  logic             in_v_i,
    output logic             in_rdy_o,
    output logic [7:0]       bus_addr_o,
    output logic [31:0]      bus_data_o,
    output logic             bus_wr_vo,
    input  logic [MAC_W:0]   bus_rdata_i,
    output logic [MAC_W:0]   res_data_o,
    output logic [5:0]       res_idx_o,
    output logic             res_v_o,
    input  logic             res_rdy_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] GD_C = CW'(GUARD);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_PRESET, S_START,
        S_WAIT, S_RA, S_RC, S_RH
    } state_t;

    state_t           state_q, state_n;
    logic [5:0]       k_q, k_n, j_q, j_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             clr_q, clr_n;
    logic [MAC_W-1:0] cdata_q, cdata_n;
    logic             busy_q, busy_n, done_q, done_n, err_q, err_n;
    logic [7:0]       addr_q, addr_n;
    logic [31:0]      data_q, data_n;
    logic             wr_q, wr_n;
    logic [MAC_W:0]   rdata_q, rdata_n;
    logic [5:0]       idx_q, idx_n;
    logic             rv_q, rv_n;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            cdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            idx_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            k_q     <= k_n;
            j_q     <= j_n;
            cnt_q   <= cnt_n;
            clr_q   <= clr_n;
            cdata_q <= cdata_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            wr_q    <= wr_n;
            rdata_q <= rdata_n;
            idx_q   <= idx_n;
            rv_q    <= rv_n;
        end
    end

    always_comb begin
        state_n = state_q;
        k_n     = k_q;
        j_n     = j_q;
        cnt_n   = cnt_q;
        clr_n   = clr_q;
        cdata_n = cdata_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        err_n   = err_q;
        addr_n  = 8'h00;
        data_n  = '0;
        wr_n    = 1'b0;
        rdata_n = rdata_q;
        idx_n   = idx_q;
        rv_n    = rv_q;
        unique case (state_q)
            S_IDLE: begin
                // a start coinciding with the done pulse is dropped
                if (cmd_start_i && !done_q) begin
                    clr_n   = cmd_clr_i;
                    cdata_n = cmd_cdata_i;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    k_n     = '0;
                    state_n = S_LOAD_W;
                end
            end
            S_LOAD_W, S_LOAD_X: begin
                if (in_v_i) begin
                    addr_n = {(state_q == S_LOAD_X) ? 2'b01 : 2'b00, k_q};
                    data_n = 32'(in_data_i);
                    wr_n   = 1'b1;
                    k_n    = k_q + 6'd1;
                    if (k_q == 6'd63) begin
                        k_n = '0;
                        if (state_q == S_LOAD_W) state_n = S_LOAD_X;
                        else state_n = clr_q ? S_PRESET : S_START;
                    end
                end
            end
            S_PRESET: begin
                addr_n  = 8'h80;
                data_n  = 32'(cdata_q);
                wr_n    = 1'b1;
                state_n = S_START;
            end
            S_START: begin
                addr_n  = 8'hC0;
                wr_n    = 1'b1;
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                cnt_n = cnt_q + 1'b1;
                if (cnt_q > GD_C && bus_rdata_i[0]) begin
                    j_n     = '0;
                    addr_n  = 8'h80;
                    state_n = S_RA;
                end else if (cnt_q == TO_C) begin
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            S_RA: begin
                addr_n  = {2'b10, j_q};
                state_n = S_RC;
            end
            S_RC: begin
                // the array registers read data, so it lands one cycle after the address
                addr_n  = {2'b10, j_q};
                rdata_n = bus_rdata_i;
                idx_n   = j_q;
                rv_n    = 1'b1;
                state_n = S_RH;
            end
            S_RH: begin
                addr_n = {2'b10, j_q};
                if (res_rdy_i) begin
                    rv_n = 1'b0;
                    if (j_q == 6'd63) begin
                        addr_n  = 8'h00;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        j_n     = j_q + 6'd1;
                        addr_n  = {2'b10, j_q + 6'd1};
                        state_n = S_RA;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign in_rdy_o   = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign bus_addr_o = addr_q;
    assign bus_data_o = data_q;
    assign bus_wr_vo  = wr_q;
    assign res_data_o = rdata_q;
    assign res_idx_o  = idx_q;
    assign res_v_o    = rv_q;

endmodule

// File: tb/tb_sa_host_seq.sv
// Bench for sa_host_seq: a behavioural array stub answers the host port and
// per-scenario tasks compare the bus trace and result stream against a model.
module tb_sa_host_seq;

    localparam int MW = 19;
    localparam int XW = 8;
    localparam int TO = 255;
    localparam int GD = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cmd_start_i = 1'b0;
    logic          cmd_clr_i = 1'b0;
    logic [MW-1:0] cmd_cdata_i = '0;
    logic          busy_o, done_o, err_o;
    logic [XW-1:0] in_data_i = '0;
    logic          in_v_i = 1'b0;
    logic          in_rdy_o;
    logic [7:0]    bus_addr_o;
    logic [31:0]   bus_data_o;
    logic          bus_wr_vo;
    logic [MW:0]   bus_rdata_i;
    logic [MW:0]   res_data_o;
    logic [5:0]    res_idx_o;
    logic          res_v_o;
    logic          res_rdy_i = 1'b1;

    always #5 clk_i = ~clk_i;

    sa_host_seq #(.MAC_W(MW), .X_W(XW), .TIMEOUT(TO), .GUARD(GD)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_start_i(cmd_start_i), .cmd_clr_i(cmd_clr_i),
        .cmd_cdata_i(cmd_cdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .in_data_i(in_data_i), .in_v_i(in_v_i), .in_rdy_o(in_rdy_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_wr_vo(bus_wr_vo), .bus_rdata_i(bus_rdata_i),
        .res_data_o(res_data_o), .res_idx_o(res_idx_o),
        .res_v_o(res_v_o), .res_rdy_i(res_rdy_i)
    );

    // array stub: 8x8 product C[col][row] = preset + sum_i W[col][i]*X[i][row]
    logic [7:0]  sw [64];
    logic [7:0]  sx [64];
    logic [18:0] spre;
    logic [19:0] sres [64];
    logic        sdone;
    int          sdly;
    bit          stub_hang = 0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus_rdata_i <= '0;
            sdone <= 1'b0;
            sdly <= 0;
            spre <= '0;
        end else begin
            if (sdly > 0) begin
                sdly <= sdly - 1;
                if (sdly == 1 && !stub_hang) sdone <= 1'b1;
            end
            if (bus_wr_vo) begin
                if (bus_addr_o[7:6] == 2'b00) sw[bus_addr_o[5:0]] <= bus_data_o[7:0];
                else if (bus_addr_o[7:6] == 2'b01) sx[bus_addr_o[5:0]] <= bus_data_o[7:0];
                else if (bus_addr_o == 8'h80) spre <= bus_data_o[18:0];
                else if (bus_addr_o == 8'hC0) begin
                    for (int j = 0; j < 64; j++) begin
                        logic [19:0] acc;
                        acc = 20'(spre);
                        for (int i = 0; i < 8; i++)
                            acc += 20'(sw[(j / 8) * 8 + i]) * 20'(sx[i * 8 + (j % 8)]);
                        sres[j] <= acc;
                    end
                    spre <= '0;
                    sdone <= 1'b0;
                    sdly <= 5;
                end
            end
            bus_rdata_i <= (!bus_wr_vo && bus_addr_o[7:6] == 2'b10)
                ? sres[bus_addr_o[5:0]] : {19'b0, sdone};
        end
    end

    int          checks = 0, passed = 0;
    int          cyc = 0, done_cnt = 0, read_cnt = 0, c0_cyc = 0, done_cyc = 0;
    logic [39:0] wr_log [$];

    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            if (bus_wr_vo) begin
                wr_log.push_back({bus_addr_o, bus_data_o});
                if (bus_addr_o == 8'hC0) c0_cyc = cyc;
            end else if (bus_addr_o[7:6] == 2'b10) read_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    logic [7:0]  wv [64];
    logic [7:0]  xv [64];
    logic [19:0] res_got [64];
    logic [5:0]  idx_got [64];
    int res_n, log_bad, res_bad, stall_bad, stall_seen, rdy_low;
    bit job_to, start_busy, start_err, ign_busy;

    function automatic logic [19:0] ref_res(input int j, input logic [18:0] pre);
        logic [19:0] s;
        s = 20'(pre);
        for (int i = 0; i < 8; i++)
            s += 20'(wv[(j / 8) * 8 + i]) * 20'(xv[i * 8 + (j % 8)]);
        return s;
    endfunction

    task automatic fill_identity();
        for (int k = 0; k < 64; k++) begin
            wv[k] = (k % 8 == k / 8) ? 8'd1 : 8'd0;
            xv[k] = 8'(k + 1);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++) begin
            wv[k] = 8'($urandom_range(0, 255));
            xv[k] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic do_job(input bit clr, input logic [18:0] cd, input int vmode,
                          input int stall_j, input int stall_n, input int abort_j,
                          input bit extra_start, input bit start_on_done);
        logic [39:0] exp_q [$];
        wr_log.delete();
        done_cnt = 0; read_cnt = 0; res_n = 0; stall_bad = 0;
        stall_seen = 0; rdy_low = 0; job_to = 0;
        @(negedge clk_i);
        cmd_start_i = 1'b1; cmd_clr_i = clr; cmd_cdata_i = cd;
        @(negedge clk_i);
        cmd_start_i = 1'b0; cmd_clr_i = 1'b0; cmd_cdata_i = '0;
        start_busy = busy_o;
        start_err = err_o;
        fork
            begin
                int idx = 0, n = 0;
                bit tog = 1;
                while (idx < 128 && n < 2000) begin
                    logic v;
                    v = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
                    tog = !tog;
                    in_v_i = v;
                    in_data_i = (idx < 64) ? wv[idx] : xv[idx - 64];
                    if (in_rdy_o !== 1'b1) rdy_low++;
                    cmd_start_i = extra_start && idx == 40;
                    cmd_clr_i = cmd_start_i;
                    cmd_cdata_i = cmd_start_i ? 19'h7 : '0;
                    @(posedge clk_i);
                    if (v) idx++;
                    n++;
                    @(negedge clk_i);
                end
                in_v_i = 1'b0; cmd_start_i = 1'b0; cmd_clr_i = 1'b0; cmd_cdata_i = '0;
                if (idx < 128) job_to = 1;
            end
            begin
                int n = 0, st = 0;
                bit seen = 0;
                logic [19:0] hd;
                logic [5:0] hi;
                logic [7:0] ha;
                while (!seen && n < 3000 && !(abort_j >= 0 && res_n >= abort_j)) begin
                    if (res_v_o && res_n == stall_j && st < stall_n) begin
                        res_rdy_i = 1'b0;
                        if (st == 0) begin
                            hd = res_data_o; hi = res_idx_o; ha = bus_addr_o;
                        end else if (res_data_o !== hd || res_idx_o !== hi || bus_addr_o !== ha)
                            stall_bad++;
                        st++;
                    end else begin
                        res_rdy_i = 1'b1;
                        if (res_v_o) begin
                            if (st > 0 && res_n == stall_j &&
                                (res_data_o !== hd || res_idx_o !== hi || bus_addr_o !== ha))
                                stall_bad++;
                            if (res_n < 64) begin
                                res_got[res_n] = res_data_o;
                                idx_got[res_n] = res_idx_o;
                            end
                            res_n++;
                        end
                    end
                    if (done_o) begin
                        seen = 1;
                        if (start_on_done) cmd_start_i = 1'b1;
                    end
                    @(negedge clk_i);
                    n++;
                end
                res_rdy_i = 1'b1;
                stall_seen = st;
                if (n >= 3000) job_to = 1;
            end
        join
        if (abort_j < 0) begin
            cmd_start_i = 1'b0;
            ign_busy = busy_o;
            repeat (3) @(negedge clk_i);
        end
        for (int k = 0; k < 64; k++) exp_q.push_back({8'(k), 32'(wv[k])});
        for (int k = 0; k < 64; k++) exp_q.push_back({8'(k + 64), 32'(xv[k])});
        if (clr) exp_q.push_back({8'h80, 32'(cd)});
        exp_q.push_back({8'hC0, 32'h0});
        log_bad = (wr_log.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++)
            if (wr_log[i] !== exp_q[i]) log_bad++;
        res_bad = 0;
        for (int j = 0; j < res_n && j < 64; j++)
            if (idx_got[j] !== 6'(j) || res_got[j] !== ref_res(j, clr ? cd : 19'h0))
                res_bad++;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy_o, done_o, err_o, in_rdy_o, bus_wr_vo, res_v_o} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000",
                     {busy_o, done_o, err_o, in_rdy_o, bus_wr_vo, res_v_o});
        else passed++;
        checks++;
        if ({bus_addr_o, bus_data_o} !== 40'h0)
            $display("FAIL reset_bus got %h want 0", {bus_addr_o, bus_data_o});
        else passed++;
        checks++;
        if ({res_data_o, res_idx_o} !== 26'h0)
            $display("FAIL reset_res got %h want 0", {res_data_o, res_idx_o});
        else passed++;
        #14 rst_i = 1'b1;
    endtask

    task automatic test_identity();
        fill_identity();
        do_job(0, '0, 0, -1, 0, -1, 0, 0);
        checks++;
        if (job_to !== 0) $display("FAIL ident_timeout got %0d want 0", job_to); else passed++;
        checks++;
        if (start_busy !== 1'b1) $display("FAIL ident_busy got %b want 1", start_busy); else passed++;
        checks++;
        if (log_bad !== 0 || wr_log.size() !== 129)
            $display("FAIL ident_buslog got %0d bad/%0d writes want 0/129", log_bad, wr_log.size());
        else passed++;
        checks++;
        if (res_n !== 64 || res_bad !== 0)
            $display("FAIL ident_results got %0d bad/%0d words want 0/64", res_bad, res_n);
        else passed++;
        checks++;
        if (res_got[63] !== 20'd64) $display("FAIL ident_last got %0d want 64", res_got[63]);
        else passed++;
        checks++;
        if (done_cnt !== 1 || err_o !== 1'b0)
            $display("FAIL ident_done got %0d/%b want 1/0", done_cnt, err_o);
        else passed++;
    endtask

    task automatic test_preset();
        fill_identity();
        do_job(1, 19'h00005, 0, -1, 0, -1, 0, 0);
        checks++;
        if (wr_log.size() !== 130 || wr_log[128] !== {8'h80, 32'h5})
            $display("FAIL preset_write got %h want 8000000005", wr_log[128]);
        else passed++;
        checks++;
        if (log_bad !== 0 || res_bad !== 0 || res_n !== 64)
            $display("FAIL preset_job got %0d/%0d/%0d want 0/0/64", log_bad, res_bad, res_n);
        else passed++;
    endtask

    task automatic test_valid_toggle();
        fill_random();
        do_job(0, '0, 1, -1, 0, -1, 0, 0);
        checks++;
        if (rdy_low !== 0) $display("FAIL toggle_rdy got %0d low want 0", rdy_low); else passed++;
        checks++;
        if (log_bad !== 0 || res_bad !== 0)
            $display("FAIL toggle_job got %0d/%0d want 0/0", log_bad, res_bad);
        else passed++;
    endtask

    task automatic test_res_stall();
        fill_random();
        do_job(0, '0, 0, 5, 10, -1, 0, 0);
        checks++;
        if (stall_seen !== 10 || stall_bad !== 0)
            $display("FAIL stall_hold got %0d/%0d want 10/0", stall_seen, stall_bad);
        else passed++;
        checks++;
        if (res_n !== 64 || res_bad !== 0 || done_cnt !== 1)
            $display("FAIL stall_job got %0d/%0d/%0d want 64/0/1", res_n, res_bad, done_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        stub_hang = 1;
        fill_identity();
        do_job(0, '0, 0, -1, 0, -1, 0, 0);
        stub_hang = 0;
        checks++;
        if (err_o !== 1'b1 || done_cnt !== 1 || busy_o !== 1'b0)
            $display("FAIL tmo_flags got %b/%0d/%b want 1/1/0", err_o, done_cnt, busy_o);
        else passed++;
        checks++;
        if (done_cyc - c0_cyc !== TO + 1)
            $display("FAIL tmo_latency got %0d want %0d", done_cyc - c0_cyc, TO + 1);
        else passed++;
        checks++;
        if (read_cnt !== 0 || res_n !== 0)
            $display("FAIL tmo_noreads got %0d/%0d want 0/0", read_cnt, res_n);
        else passed++;
    endtask

    task automatic test_back_to_back();
        fill_identity();
        do_job(0, '0, 0, -1, 0, -1, 0, 1);
        checks++;
        if (start_err !== 1'b0) $display("FAIL b2b_errclr got %b want 0", start_err); else passed++;
        checks++;
        if (ign_busy !== 1'b0) $display("FAIL b2b_ignore got %b want 0", ign_busy); else passed++;
        checks++;
        if (res_bad !== 0 || res_n !== 64 || done_cnt !== 1)
            $display("FAIL b2b_job got %0d/%0d/%0d want 0/64/1", res_bad, res_n, done_cnt);
        else passed++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            logic [18:0] cd;
            bit clr;
            fill_random();
            cd = 19'($urandom);
            clr = 1'($urandom_range(0, 1));
            do_job(clr, cd, 2, -1, 0, -1, 1, 0);
            checks++;
            if (log_bad !== 0 || res_bad !== 0 || res_n !== 64 || done_cnt !== 1)
                $display("FAIL random%0d got %0d/%0d/%0d/%0d want 0/0/64/1",
                         r, log_bad, res_bad, res_n, done_cnt);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_read();
        fill_random();
        do_job(0, '0, 0, -1, 0, 30, 0, 0);
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, in_rdy_o, bus_wr_vo, res_v_o, bus_addr_o} !== 14'h0)
            $display("FAIL midrst_flags got %h want 0",
                     {busy_o, done_o, err_o, in_rdy_o, bus_wr_vo, res_v_o, bus_addr_o});
        else passed++;
        checks++;
        if ({bus_data_o, res_data_o, res_idx_o} !== 58'h0)
            $display("FAIL midrst_data got %h want 0", {bus_data_o, res_data_o, res_idx_o});
        else passed++;
        @(negedge clk_i);
        rst_i = 1'b1;
        fill_identity();
        do_job(1, 19'h1234, 0, -1, 0, -1, 0, 0);
        checks++;
        if (log_bad !== 0 || res_bad !== 0 || res_n !== 64 || done_cnt !== 1)
            $display("FAIL midrst_rerun got %0d/%0d/%0d/%0d want 0/0/64/1",
                     log_bad, res_bad, res_n, done_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_preset();
        test_valid_toggle();
        test_res_stall();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
